// File: rtl/core_types_pkg.sv
// Shared core types: data-memory request control, access sizes and the
// responder FSM state encoding.
package core_types_pkg;

  typedef enum logic {
    DMEM_LOAD  = 1'b0,
    DMEM_STORE = 1'b1
  } dmem_op_t;

  typedef enum logic [1:0] {
    DMEM_BYTE = 2'd0,
    DMEM_HALF = 2'd1,
    DMEM_WORD = 2'd2
  } dmem_size_t;

  typedef struct packed {
    dmem_op_t   op;
    dmem_size_t size;
    logic       is_unsigned;
  } dmem_req_ctrl_t;

  typedef enum logic [1:0] {
    DMEM_RSP_IDLE = 2'd0,
    DMEM_RSP_WAIT = 2'd1,
    DMEM_RSP_RESP = 2'd2
  } dmem_rsp_state_t;

  // Latency counter width; covers the legal LATENCY range 1..15.
  localparam int unsigned DMEM_LAT_W = 4;

  // True when the low address bits are not a multiple of the access size.
  function automatic logic dmem_misaligned(input dmem_size_t size, input logic [1:0] lane);
    case (size)
      DMEM_BYTE: return 1'b0;
      DMEM_HALF: return lane[0];
      default:   return (lane != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load alignment: selects the addressed byte/half of a memory word,
// right-aligns it and sign- or zero-extends it. The lane must already be
// aligned to the access size by the caller.
module dmem_load_align
  import core_types_pkg::*;
#(
  parameter int N_BITS = 32
) (
  input  logic [N_BITS-1:0] word_i,
  input  logic [1:0]        lane_i,
  input  dmem_size_t        size_i,
  input  logic              is_unsigned_i,
  output logic [N_BITS-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{lane_i, 3'b000} +: 8];
  assign half_sel = word_i[{lane_i[1], 4'b0000} +: 16];

  // Extend the selected lane to the full data width.
  always_comb begin
    // NOTE: data_o gets a default before the case so no path leaves it unassigned (no latch).
    data_o = word_i;
    case (size_i)
      DMEM_BYTE: data_o = {{(N_BITS-8){~is_unsigned_i & byte_sel[7]}}, byte_sel};
      DMEM_HALF: data_o = {{(N_BITS-16){~is_unsigned_i & half_sel[15]}}, half_sel};
      default:   data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store over valid/ready,
// byte/half/word access on a word-organised array, response after LATENCY.
// Optional build macro DMEM_MISALIGN_CHECK_EN: flag misaligned half/word
// accesses on resp_err and suppress their stores; otherwise misaligned low
// address bits are silently cleared and resp_err is tied low.
module dmem_responder
  import core_types_pkg::*;
#(
  parameter int N_BITS      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_val,
  output logic              req_rdy,
  input  dmem_req_ctrl_t    req_ctrl,
  input  logic [N_BITS-1:0] req_addr,
  input  logic [N_BITS-1:0] req_wdata,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic [N_BITS-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int NB = N_BITS / 8;
  localparam logic [DMEM_LAT_W-1:0] LAT_INIT = DMEM_LAT_W'(LATENCY - 1);

  dmem_rsp_state_t         state_q, state_d;
  logic [DMEM_LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [N_BITS-1:0]       resp_rdata_q, resp_rdata_d;

  logic                    accept;
  logic [AW-1:0]           word_idx;
  logic [1:0]              lane;
  logic [1:0]              eff_lane;
  logic                    misaligned;
  logic                    wr_en;
  logic [NB-1:0]           byte_en;
  logic [N_BITS-1:0]       wdata_rep;
  logic [N_BITS-1:0]       rd_word;
  logic [N_BITS-1:0]       load_data;

  logic [N_BITS-1:0]       mem [DEPTH_WORDS];

  // Upper address bits are ignored: addresses wrap modulo the memory size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[N_BITS-1:AW+2];

  assign word_idx = req_addr[AW+1:2];
  assign lane     = req_addr[1:0];

  // Handshake outputs derived from the current state.
  always_comb begin
    req_rdy  = (state_q == DMEM_RSP_IDLE) && !rst;
    resp_val = (state_q == DMEM_RSP_RESP);
  end

  assign accept = req_val && req_rdy;

  // Lane alignment, misalignment detection and store byte enables.
  always_comb begin
    eff_lane  = lane;
    byte_en   = '1;
    wdata_rep = req_wdata;
    case (req_ctrl.size)
      DMEM_BYTE: begin
        eff_lane  = lane;
        byte_en   = {{(NB-1){1'b0}}, 1'b1} << eff_lane;
        wdata_rep = {NB{req_wdata[7:0]}};
      end
      DMEM_HALF: begin
        eff_lane  = {lane[1], 1'b0};
        byte_en   = {{(NB-2){1'b0}}, 2'b11} << eff_lane;
        wdata_rep = {(NB/2){req_wdata[15:0]}};
      end
      default: begin
        eff_lane  = 2'b00;
        byte_en   = '1;
        wdata_rep = req_wdata;
      end
    endcase
`ifdef DMEM_MISALIGN_CHECK_EN
    misaligned = dmem_misaligned(req_ctrl.size, lane);
`else
    misaligned = 1'b0;
`endif
    wr_en = accept && (req_ctrl.op == DMEM_STORE) && !misaligned;
  end

  // Byte-lane writes into the array, committed on the acceptance edge.
  // NOTE: the array is deliberately not reset; contents stay undefined until written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  assign rd_word = mem[word_idx];

  dmem_load_align #(.N_BITS(N_BITS)) u_load_align (
    .word_i        (rd_word),
    .lane_i        (eff_lane),
    .size_i        (req_ctrl.size),
    .is_unsigned_i (req_ctrl.is_unsigned),
    .data_o        (load_data)
  );

  // Next-state logic: accept, count out the latency, hold until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DMEM_RSP_IDLE: if (accept) state_d = (LATENCY == 1) ? DMEM_RSP_RESP : DMEM_RSP_WAIT;
      DMEM_RSP_WAIT: if (lat_cnt_q <= 1) state_d = DMEM_RSP_RESP;
      DMEM_RSP_RESP: if (resp_rdy) state_d = DMEM_RSP_IDLE;
      default:       state_d = DMEM_RSP_IDLE;
    endcase
  end

  // Datapath next values: latency counter and captured response data.
  always_comb begin
    lat_cnt_d    = lat_cnt_q;
    resp_rdata_d = resp_rdata_q;
    if (accept) begin
      lat_cnt_d    = LAT_INIT;
      resp_rdata_d = (req_ctrl.op == DMEM_LOAD && !misaligned) ? load_data : '0;
    end else if (state_q == DMEM_RSP_WAIT) begin
      lat_cnt_d = lat_cnt_q - 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= DMEM_RSP_IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt_q    <= '0;
      resp_rdata_q <= '0;
    end else begin
      lat_cnt_q    <= lat_cnt_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_rdata = resp_rdata_q;

`ifdef DMEM_MISALIGN_CHECK_EN
  logic resp_err_q, resp_err_d;

  // Error flag captured at acceptance and held through the response.
  always_comb begin
    resp_err_d = resp_err_q;
    if (accept) resp_err_d = misaligned;
  end

  // Error flag register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) resp_err_q <= 1'b0;
    else     resp_err_q <= resp_err_d;
  end

  assign resp_err = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios followed by
// random loads/stores, checked against a byte-array reference model.
module tb_dmem_responder;
  import core_types_pkg::*;

  localparam int N_BITS    = 32;
  localparam int DEPTH     = 1024;
  localparam int LAT       = 2;
  localparam int MEM_BYTES = DEPTH * 4;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              req_val;
  logic              req_rdy;
  dmem_req_ctrl_t    req_ctrl;
  logic [N_BITS-1:0] req_addr;
  logic [N_BITS-1:0] req_wdata;
  logic              resp_val;
  logic              resp_rdy;
  logic [N_BITS-1:0] resp_rdata;
  logic              resp_err;

  dmem_responder #(.N_BITS(N_BITS), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_ctrl   (req_ctrl),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_val   (resp_val),
    .resp_rdy   (resp_rdy),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: little-endian byte array.
  logic [7:0]  mem_m [MEM_BYTES];
  logic [31:0] exp_data;
  logic        exp_err;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic dmem_req_ctrl_t mk(input dmem_op_t op, input dmem_size_t sz, input logic uns);
    dmem_req_ctrl_t c;
    c.op = op;
    c.size = sz;
    c.is_unsigned = uns;
    return c;
  endfunction

  // Apply one access to the model and produce the expected response.
  task automatic model_access(input dmem_req_ctrl_t c, input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned nbytes;
    int unsigned a;
    logic [31:0] v;
    nbytes = (c.size == DMEM_BYTE) ? 1 : (c.size == DMEM_HALF) ? 2 : 4;
    a = addr % MEM_BYTES;
    exp_err = 1'b0;
    exp_data = '0;
    if (CHK && (a % nbytes) != 0) begin
      exp_err = 1'b1;
      return;
    end
    a = a - (a % nbytes);
    if (c.op == DMEM_STORE) begin
      for (int i = 0; i < int'(nbytes); i++) mem_m[a + i] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < int'(nbytes); i++) v[8*i +: 8] = mem_m[a + i];
      if (!c.is_unsigned && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
      exp_data = v;
    end
  endtask

  // Present a request from a negedge, wait for acceptance, then drop req_val.
  task automatic send(input dmem_req_ctrl_t c, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    req_ctrl = c;
    req_addr = a;
    req_wdata = d;
    req_val = 1'b1;
    while (!req_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_rdy", {31'd0, req_rdy}, 32'd1);
    @(posedge clk);
    if (req_rdy) model_access(c, a, d);
    @(negedge clk);
    req_val = 1'b0;
  endtask

  // Wait (bounded) for the response, check latency/data/err, consume it.
  // Called at the negedge right after the acceptance edge; the response
  // is expected LAT-1 edges later (LAT periods after the request appeared).
  task automatic expect_resp(input string tag);
    int n;
    n = 0;
    while (!resp_val && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, LAT - 1);
    check({tag, "_data"}, resp_rdata, exp_data);
    check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    last_rdata = resp_rdata;
    last_err = resp_err;
    @(negedge clk);
    check({tag, "_drop"}, {31'd0, resp_val}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int n;
    dmem_req_ctrl_t c;
    logic [31:0] a;

    rst = 1'b1;
    req_val = 1'b0;
    req_ctrl = mk(DMEM_LOAD, DMEM_WORD, 1'b0);
    req_addr = '0;
    req_wdata = '0;
    resp_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_resp_val", {31'd0, resp_val}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    check("rst_req_rdy", {31'd0, req_rdy}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_req_rdy", {31'd0, req_rdy}, 32'd1);
    @(negedge clk);

    // Initialise a 256-byte region so every later load reads defined data.
    for (int w = 0; w < 64; w++) begin
      send(mk(DMEM_STORE, DMEM_WORD, 1'b0), 32'(w * 4), $urandom);
      expect_resp("init_st");
    end

    // Word store/load and byte sign/zero extension.
    send(mk(DMEM_STORE, DMEM_WORD, 1'b0), 32'h10, 32'hDEAD_BEEF);
    expect_resp("st_word");
    check("st_word_zero", last_rdata, 32'd0);
    send(mk(DMEM_LOAD, DMEM_WORD, 1'b0), 32'h10, 32'h0);
    expect_resp("ld_word");
    check("ld_word_plan", last_rdata, 32'hDEAD_BEEF);
    send(mk(DMEM_STORE, DMEM_BYTE, 1'b0), 32'h13, 32'h1234_5680);
    expect_resp("st_byte");
    send(mk(DMEM_LOAD, DMEM_BYTE, 1'b0), 32'h13, 32'h0);
    expect_resp("ld_sbyte");
    check("ld_sbyte_plan", last_rdata, 32'hFFFF_FF80);
    send(mk(DMEM_LOAD, DMEM_BYTE, 1'b1), 32'h13, 32'h0);
    expect_resp("ld_ubyte");
    check("ld_ubyte_plan", last_rdata, 32'h0000_0080);
    send(mk(DMEM_LOAD, DMEM_WORD, 1'b0), 32'h10, 32'h0);
    expect_resp("ld_word2");
    check("ld_word2_plan", last_rdata, 32'h80AD_BEEF);
    send(mk(DMEM_LOAD, DMEM_HALF, 1'b0), 32'h12, 32'h0);
    expect_resp("ld_shalf");

    // Back-pressure: response held, competing request ignored until consumed.
    resp_rdy = 1'b0;
    send(mk(DMEM_LOAD, DMEM_WORD, 1'b0), 32'h10, 32'h0);
    n = 0;
    while (!resp_val && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hold_lat", n, LAT - 1);
    check("hold_data0", resp_rdata, exp_data);
    held = resp_rdata;
    req_ctrl = mk(DMEM_STORE, DMEM_WORD, 1'b0);
    req_addr = 32'h40;
    req_wdata = 32'h1111_2222;
    req_val = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("hold_val", {31'd0, resp_val}, 32'd1);
      check("hold_data", resp_rdata, held);
      check("hold_req_rdy", {31'd0, req_rdy}, 32'd0);
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    check("hold_released", {31'd0, resp_val}, 32'd0);
    check("hold_rdy_back", {31'd0, req_rdy}, 32'd1);
    @(posedge clk);
    model_access(mk(DMEM_STORE, DMEM_WORD, 1'b0), 32'h40, 32'h1111_2222);
    @(negedge clk);
    req_val = 1'b0;
    expect_resp("held_st");
    send(mk(DMEM_LOAD, DMEM_WORD, 1'b0), 32'h40, 32'h0);
    expect_resp("held_ld");

    // Reset while a load is waiting: the response never appears.
    send(mk(DMEM_LOAD, DMEM_WORD, 1'b0), 32'h10, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rstw_val", {31'd0, resp_val}, 32'd0);
    check("rstw_req_rdy", {31'd0, req_rdy}, 32'd0);
    rst = 1'b0;
    #1;
    check("rstw_idle", {31'd0, req_rdy}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("rstw_no_resp", {31'd0, resp_val}, 32'd0);
    end

    // Reset after a store was accepted: the write stays committed.
    send(mk(DMEM_STORE, DMEM_WORD, 1'b0), 32'h44, 32'hCAFE_F00D);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(mk(DMEM_LOAD, DMEM_WORD, 1'b0), 32'h44, 32'h0);
    expect_resp("rsts_ld");
    check("rsts_plan", last_rdata, 32'hCAFE_F00D);

    // Misaligned word store at 0x21.
    send(mk(DMEM_STORE, DMEM_WORD, 1'b0), 32'h21, 32'hA5A5_5A5A);
    expect_resp("mis_st");
`ifdef DMEM_MISALIGN_CHECK_EN
    check("mis_err_plan", {31'd0, last_err}, 32'd1);
`else
    check("mis_err_plan", {31'd0, last_err}, 32'd0);
`endif
    send(mk(DMEM_LOAD, DMEM_WORD, 1'b0), 32'h20, 32'h0);
    expect_resp("mis_ld");

    // Random traffic inside the initialised region, random upper address bits.
    for (int i = 0; i < 60; i++) begin
      c = mk(dmem_op_t'($urandom_range(0, 1)), dmem_size_t'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)));
      a = {$urandom_range(0, 32'hF_FFFF), 4'h0, 8'($urandom_range(0, 255))};
      send(c, a, $urandom);
      expect_resp("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
